ahb_flash_writer_spi_engine: RTL and testbench



---
 rtl/fw_pkg.sv | 31 +++
 rtl/ahb_flash_writer_spi_engine_if.sv | 22 ++
 rtl/fw_sync_fifo.sv | 44 ++++
 rtl/ahb_flash_writer_spi_engine.sv | 199 +++++++++++++++++++
 tb/tb_ahb_flash_writer_spi_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fw_pkg.sv
// Shared constants for the AHB flash writer SPI engine: register offsets,
// write-enable key, engine states and STATUS bit positions.
package fw_pkg;

  localparam logic [4:0] OFF_WE     = 5'h00;
  localparam logic [4:0] OFF_SS     = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_IRQEN  = 5'h0C;
  localparam logic [4:0] OFF_TXDATA = 5'h10;
  localparam logic [4:0] OFF_RXDATA = 5'h14;
  localparam logic [4:0] OFF_STATUS = 5'h18;
  localparam logic [4:0] OFF_ID     = 5'h1C;

  localparam logic [31:0] WE_KEY = 32'hA5A85501;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SCK_LO = 3'd2,
    SCK_HI = 3'd3,
    DONE   = 3'd4
  } fw_state_e;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TXFULL  = 1;
  localparam int unsigned ST_TXEMPTY = 2;
  localparam int unsigned ST_RXFULL  = 3;
  localparam int unsigned ST_RXEMPTY = 4;
  localparam int unsigned ST_OVF     = 5;

endpackage

// File: rtl/ahb_flash_writer_spi_engine_if.sv
// AHB-Lite slave-side bus bundle for the flash writer SPI engine.
interface ahb_flash_writer_spi_engine_if;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    output HREADYOUT, HRDATA
  );

  modport master (
    output HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    input  HREADYOUT, HRDATA
  );
endinterface

// File: rtl/fw_sync_fifo.sv
// Single-clock FIFO; a push on a full FIFO is accepted when a pop happens
// in the same cycle.
module fw_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/ahb_flash_writer_spi_engine.sv
// AHB-Lite flash writer with TX/RX byte FIFOs and a single/quad SPI shift engine.
// Optional FW_IRQ_EN adds the irq output and the IRQEN register at 0x0C.
module ahb_flash_writer_spi_engine
  import fw_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned RX_DEPTH    = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1,
  parameter logic [31:0] MAGIC       = 32'hABCD0002
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  ahb_flash_writer_spi_engine_if.slave  bus,
  output logic                          fm_sck,
  output logic                          fm_ce_n,
  output logic [3:0]                    fm_dout,
  output logic [3:0]                    fm_douten,
  input  logic [3:0]                    fm_din
`ifdef FW_IRQ_EN
  ,
  output logic                          irq
`endif
);

  logic             ap_valid, ap_write;
  logic [4:0]       ap_addr;
  logic             hready, wr, wr_en, rd, ss_pend;
  logic             en, ce_n, quad, qdir, ovf;
  logic [DIV_W-1:0] div, cnt;
  fw_state_e        state;
  logic [7:0]       shreg, rxsh;
  logic [3:0]       nbits;
  logic             busy;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       tx_dout, rx_dout;
  logic [31:0]      rdata;
  logic             unused_bits;
`ifdef FW_IRQ_EN
  logic [2:0]       irqen;
`endif

  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= '0;
    end else if (bus.HREADY) begin
      ap_valid <= bus.HSEL & bus.HTRANS[1];
      ap_write <= bus.HWRITE;
      ap_addr  <= {bus.HADDR[4:2], 2'b00};
    end
  end

  // An SS write waits for the engine to drain so CE never changes mid-byte.
  assign busy    = (state != IDLE) | ~tx_empty;
  assign ss_pend = ap_valid & ap_write & en & (ap_addr == OFF_SS);
  assign hready  = ~(ss_pend & ~((state == IDLE) & tx_empty));
  assign wr      = ap_valid & ap_write & hready;
  assign wr_en   = wr & en;
  assign rd      = ap_valid & ~ap_write;

  assign tx_push = wr_en & (ap_addr == OFF_TXDATA);
  assign tx_pop  = (state == LOAD);
  assign rx_pop  = rd & (ap_addr == OFF_RXDATA);
  assign rx_push = (state == DONE) & (~quad | qdir);

  fw_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(tx_push), .din(bus.HWDATA[7:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  fw_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(rx_push), .din(rxsh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en    <= 1'b0;
      ce_n  <= 1'b1;
      quad  <= 1'b0;
      qdir  <= 1'b0;
      div   <= DIV_W'(DEFAULT_DIV);
      ovf   <= 1'b0;
`ifdef FW_IRQ_EN
      irqen <= '0;
`endif
    end else begin
      if (wr && ap_addr == OFF_WE) en <= (bus.HWDATA == WE_KEY);
      if (wr_en) begin
        case (ap_addr)
          OFF_SS:     ce_n <= bus.HWDATA[0];
          OFF_CTRL:   if (!busy) begin
                        quad <= bus.HWDATA[0];
                        qdir <= bus.HWDATA[1];
                        div  <= bus.HWDATA[8 +: DIV_W];
                      end
`ifdef FW_IRQ_EN
          OFF_IRQEN:  irqen <= bus.HWDATA[2:0];
`endif
          OFF_STATUS: if (bus.HWDATA[ST_OVF]) ovf <= 1'b0;
          default:    ;
        endcase
      end
      if (tx_push && tx_full && !tx_pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      shreg <= '0;
      rxsh  <= '0;
      nbits <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:   if (en && !tx_empty && !rx_full) state <= LOAD;
        LOAD: begin
          shreg <= tx_dout;
          nbits <= quad ? 4'd2 : 4'd8;
          cnt   <= '0;
          state <= SCK_LO;
        end
        SCK_LO: begin
          if (cnt == div) begin
            cnt   <= '0;
            rxsh  <= quad ? {rxsh[3:0], fm_din} : {rxsh[6:0], fm_din[1]};
            state <= SCK_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCK_HI: begin
          if (cnt == div) begin
            cnt   <= '0;
            shreg <= quad ? {shreg[3:0], 4'b0000} : {shreg[6:0], 1'b0};
            nbits <= nbits - 1'b1;
            state <= (nbits == 4'd1) ? DONE : SCK_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The shift register empties itself, so fm_dout returns to 0 between bytes.
  assign fm_sck    = (state == SCK_HI);
  assign fm_ce_n   = ce_n;
  assign fm_dout   = quad ? shreg[7:4] : {3'b000, shreg[7]};
  assign fm_douten = !quad ? 4'b0001 : (qdir ? 4'b0000 : 4'b1111);

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (ap_addr)
        OFF_WE:     rdata[0] = en;
        OFF_SS:     rdata[0] = ce_n;
        OFF_CTRL: begin
          rdata[0]          = quad;
          rdata[1]          = qdir;
          rdata[8 +: DIV_W] = div;
        end
`ifdef FW_IRQ_EN
        OFF_IRQEN:  rdata[2:0] = irqen;
`endif
        OFF_RXDATA: if (!rx_empty) rdata[7:0] = rx_dout;
        OFF_STATUS: begin
          rdata[ST_BUSY]    = busy;
          rdata[ST_TXFULL]  = tx_full;
          rdata[ST_TXEMPTY] = tx_empty;
          rdata[ST_RXFULL]  = rx_full;
          rdata[ST_RXEMPTY] = rx_empty;
          rdata[ST_OVF]     = ovf;
        end
        OFF_ID:     rdata = MAGIC;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = hready;

`ifdef FW_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq <= 1'b0;
    else          irq <= |(irqen & {ovf, ~rx_empty, tx_empty & ~busy});
  end
`endif

endmodule

// File: tb/tb_ahb_flash_writer_spi_engine.sv
// Scoreboard bench for ahb_flash_writer_spi_engine: bus reads and SPI bit
// expectations are queued at stimulus time and checked by monitor processes.
module tb_ahb_flash_writer_spi_engine;
  localparam logic [31:0] A_WE = 32'h00, A_SS = 32'h04, A_CTRL = 32'h08;
  localparam logic [31:0] A_TX = 32'h10, A_RX = 32'h14, A_ST = 32'h18, A_ID = 32'h1C;
  localparam logic [31:0] KEY = 32'hA5A85501, MAGIC = 32'hABCD0002;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_flash_writer_spi_engine_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  logic       fm_sck, fm_ce_n;
  logic [3:0] fm_dout, fm_douten, fm_din;
`ifdef FW_IRQ_EN
  logic       irq;
`endif

  ahb_flash_writer_spi_engine #(
    .TX_DEPTH(4), .RX_DEPTH(4), .DIV_W(8), .DEFAULT_DIV(1), .MAGIC(MAGIC)
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .fm_sck(fm_sck), .fm_ce_n(fm_ce_n), .fm_dout(fm_dout),
    .fm_douten(fm_douten), .fm_din(fm_din)
`ifdef FW_IRQ_EN
    , .irq(irq)
`endif
  );

  int total = 0;
  int bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  spi_exp_q[$];
  bit          mon_rd = 1'b0;
  bit          spi_track = 1'b1;
  int          pulse_cnt = 0;
  int          hi_len = 0;
  int          exp_hi = 2;
  logic        sck_d = 1'b0;

  // Flash model: serial byte on din[1] advancing on each SCK fall, or a constant quad nibble.
  logic [7:0] flash_byte = 8'h00;
  int         fall_cnt = 0;
  int         fall_base = 0;
  bit         din_quad = 1'b0;
  logic [3:0] din_const = 4'h0;

  always @(negedge fm_sck) fall_cnt++;

  always_comb begin
    fm_din = din_quad ? din_const : 4'b0000;
    if (!din_quad && (fall_cnt - fall_base) >= 0 && (fall_cnt - fall_base) < 8)
      fm_din[1] = flash_byte[3'(7 - (fall_cnt - fall_base))];
  end

  always @(negedge HCLK) begin
    if (mon_rd && bus.HREADYOUT) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %h expected none", bus.HRDATA);
      end else begin
        check(rd_name_q.pop_front(), bus.HRDATA, rd_exp_q.pop_front());
      end
    end
    if (fm_sck && !sck_d) begin
      pulse_cnt++;
      hi_len = 0;
      if (spi_track) begin
        if (spi_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spi_extra: got oe/dout %h expected no pulse", {fm_douten, fm_dout});
        end else begin
          check("spi_bit", {24'h0, fm_douten, fm_dout}, {24'h0, spi_exp_q.pop_front()});
        end
      end
    end
    if (fm_sck) hi_len++;
    if (!fm_sck && sck_d && spi_track) check("sck_hi_width", 32'(hi_len), 32'(exp_hi));
    sck_d = fm_sck;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, output int stall);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = data;
    stall = 0;
    while (!bus.HREADYOUT && stall < 300) begin
      @(posedge HCLK); #1;
      stall++;
    end
    if (!bus.HREADYOUT) begin
      total++; bad++;
      $display("FAIL write_timeout: got HREADYOUT 0 expected 1 at addr %h", addr);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    int s;
    ahb_write(addr, data, s);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    mon_rd = 1'b1;
    @(posedge HCLK); #1;
    mon_rd = 1'b0;
  endtask

  task automatic exp_byte(input logic [7:0] b, input bit q, input logic [3:0] oe);
    if (q) begin
      spi_exp_q.push_back({oe, b[7:4]});
      spi_exp_q.push_back({oe, b[3:0]});
    end else begin
      for (int i = 7; i >= 0; i--) spi_exp_q.push_back({oe, 3'b000, b[i]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0, st;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HADDR = '0; bus.HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_sck", 32'(fm_sck), 32'd0);
    check("rst_ce_n", 32'(fm_ce_n), 32'd1);
    check("rst_dout", 32'(fm_dout), 32'd0);
    check("rst_douten", 32'(fm_douten), 32'd1);
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    HRESETn = 1'b1;
    idle(1);

    rd(A_ID, MAGIC, "id");
    rd(A_WE, 32'd0, "we_rst");
    rd(A_CTRL, 32'h100, "ctrl_rst");
    p0 = pulse_cnt;
    wr(A_TX, 32'h9F);
    idle(20);
    check("no_sck_when_disabled", 32'(pulse_cnt - p0), 32'd0);
    rd(A_ST, 32'h14, "status_disabled");

    // Single lane, div=1, flash answers 0xBF.
    wr(A_WE, KEY);
    rd(A_WE, 32'd1, "we_set");
    wr(A_SS, 32'd0);
    rd(A_SS, 32'd0, "ss_low");
    wr(A_CTRL, 32'h100);
    flash_byte = 8'hBF;
    fall_base = fall_cnt;
    exp_byte(8'h9F, 1'b0, 4'b0001);
    p0 = pulse_cnt;
    wr(A_TX, 32'h9F);
    idle(50);
    check("single_pulses", 32'(pulse_cnt - p0), 32'd8);
    rd(A_RX, 32'hBF, "rx_single");
    rd(A_ST, 32'h14, "status_single");
    flash_byte = 8'h00;

    // Quad write: nothing lands in RX.
    wr(A_CTRL, 32'h101);
    rd(A_CTRL, 32'h101, "ctrl_quad_wr");
    check("douten_quad_wr", 32'(fm_douten), 32'hF);
    exp_byte(8'hA5, 1'b1, 4'hF);
    p0 = pulse_cnt;
    wr(A_TX, 32'hA5);
    idle(30);
    check("quad_wr_pulses", 32'(pulse_cnt - p0), 32'd2);
    rd(A_ST, 32'h14, "status_quad_wr");

    // Quad read with din held at 3.
    wr(A_CTRL, 32'h103);
    check("douten_quad_rd", 32'(fm_douten), 32'h0);
    din_quad = 1'b1;
    din_const = 4'h3;
    exp_byte(8'h00, 1'b1, 4'h0);
    wr(A_TX, 32'h00);
    idle(30);
    rd(A_RX, 32'h33, "rx_quad");
    din_quad = 1'b0;

    // SS write stalls across two queued bytes (~35 cycles each).
    wr(A_CTRL, 32'h100);
    exp_byte(8'h3C, 1'b0, 4'b0001);
    exp_byte(8'hC3, 1'b0, 4'b0001);
    wr(A_TX, 32'h3C);
    wr(A_TX, 32'hC3);
    ahb_write(A_SS, 32'd1, st);
    check("ss_stall_spans_both_bytes", 32'(st >= 60 && st <= 75), 32'd1);
    check("ce_n_after_ss", 32'(fm_ce_n), 32'd1);
    check("spi_done_before_ce", 32'(spi_exp_q.size()), 32'd0);
    rd(A_ST, 32'h04, "status_after_ss");
    wr(A_SS, 32'd0);

    // Fill RX to hold the engine, then overflow TX.
    spi_track = 1'b0;
    wr(A_CTRL, 32'h000);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    idle(50);
    rd(A_ST, 32'h0C, "status_rx_full");
    for (int i = 1; i <= 5; i++) wr(A_TX, 32'(i));
    rd(A_ST, 32'h2B, "status_ovf");
    wr(A_ST, 32'h20);
    rd(A_ST, 32'h0B, "status_ovf_clr");

    // Popping RX releases the engine; reset lands mid-byte.
    rd(A_RX, 32'h00, "rx_pop_release");
    p0 = pulse_cnt;
    idle(6);
    check("mid_byte", 32'(pulse_cnt - p0 >= 1 && pulse_cnt - p0 < 8), 32'd1);
    #3;
    HRESETn = 1'b0;
    #1;
    check("async_rst_sck", 32'(fm_sck), 32'd0);
    check("async_rst_ce_n", 32'(fm_ce_n), 32'd1);
    check("async_rst_dout", 32'(fm_dout), 32'd0);
    check("async_rst_douten", 32'(fm_douten), 32'd1);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle(1);
    rd(A_ST, 32'h14, "status_post_rst");
    rd(A_WE, 32'd0, "we_post_rst");
    rd(A_ID, MAGIC, "id_post_rst");
    idle(2);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
